// File: rtl/fb_pkg.sv
// Shared types for the framebuffer port arbiter: BRAM geometry, grant encoding
// and the write-request record carried through the write FIFO.
package fb_pkg;

  localparam int FB_AW = 15;
  localparam int FB_DW = 16;

  typedef enum logic [1:0] {
    G_NONE = 2'd0,
    G_RD   = 2'd1,
    G_WR   = 2'd2
  } grant_t;

  typedef struct packed {
    logic [FB_AW-1:0] addr;
    logic [FB_DW-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/fb_wr_fifo.sv
// Small synchronous FIFO of pending pixel writes; pointers carry one extra MSB
// so that full and empty can be told apart without a separate counter.
module fb_wr_fifo
  import fb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic          PixelClk,
  input  logic          nRST,
  input  logic          push,
  input  wr_req_t       push_req,
  input  logic          pop,
  output wr_req_t       head,
  output logic          full,
  output logic          empty,
  output logic [PW:0]   level
);

  localparam logic [PW:0] PTR_ONE = 1;

  logic [PW:0] wr_ptr;
  logic [PW:0] rd_ptr;
  wr_req_t     mem [DEPTH];

  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage needs no reset: entries are only visible between the pointers.
  always_ff @(posedge PixelClk) begin
    if (push) mem[wr_ptr[PW-1:0]] <= push_req;
  end

  assign head  = mem[rd_ptr[PW-1:0]];
  assign level = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

endmodule

// File: rtl/fb_port_arbiter.sv
// Arbitrates the single-port framebuffer BRAM between LCD scan-out (always wins)
// and queued pixel writes, which drain in slots freed by repeated read addresses.
module fb_port_arbiter
  import fb_pkg::*;
#(
  parameter int AW         = FB_AW,
  parameter int DW         = FB_DW,
  parameter int FIFO_DEPTH = 4,
  parameter int STALL_W    = 16,
  localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic               PixelClk,
  input  logic               nRST,
  input  logic               rd_en,
  input  logic [AW-1:0]      rd_addr,
  input  logic               rd_refetch,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [AW-1:0]      wr_addr,
  input  logic [DW-1:0]      wr_data,
  output logic               ram_ce,
  output logic               ram_wre,
  output logic [AW-1:0]      ram_ad,
  output logic [DW-1:0]      ram_din,
  output logic [LW-1:0]      fifo_level,
  output logic [STALL_W-1:0] stall_cnt
);

  localparam logic [STALL_W-1:0] STALL_ONE = 1;

  grant_t        grant;
  grant_t        grant_d;
  logic          need_rd;
  logic          hv;
  logic          rdy;
  logic [AW-1:0] held_addr;
  wr_req_t       push_req;
  wr_req_t       head;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  assign wr_ready = rdy & ~full;
  assign push     = wr_valid & wr_ready;
  assign pop      = (grant_d == G_WR);
  assign push_req = '{addr: wr_addr, data: wr_data};

  fb_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_wr_fifo (
    .PixelClk (PixelClk),
    .nRST     (nRST),
    .push     (push),
    .push_req (push_req),
    .pop      (pop),
    .head     (head),
    .full     (full),
    .empty    (empty),
    .level    (fifo_level)
  );

  // A read is only needed when the address differs from what the BRAM already holds.
  always_comb begin
    need_rd = rd_en & (~hv | (rd_addr != held_addr));
    grant_d = G_NONE;
    if (need_rd)     grant_d = G_RD;
    else if (!empty) grant_d = G_WR;
  end

  assign ram_ce  = (grant != G_NONE);
  assign ram_wre = (grant == G_WR);

  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      rdy       <= 1'b0;
      grant     <= G_NONE;
      ram_ad    <= '0;
      ram_din   <= '0;
      held_addr <= '0;
      hv        <= 1'b0;
      stall_cnt <= '0;
    end else begin
      rdy   <= 1'b1;
      grant <= grant_d;
      if (rd_refetch) hv <= 1'b0;
      unique case (grant_d)
        G_RD: begin
          ram_ad    <= rd_addr;
          held_addr <= rd_addr;
          hv        <= 1'b1;
        end
        G_WR: begin
          ram_ad  <= head.addr;
          ram_din <= head.data;
          // Overwriting the held pixel makes the cached read stale.
          if (head.addr == held_addr) hv <= 1'b0;
        end
        default: ;
      endcase
      if (!empty && grant_d == G_RD && stall_cnt != '1)
        stall_cnt <= stall_cnt + STALL_ONE;
    end
  end

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed bench for fb_port_arbiter: expected BRAM accesses are queued as
// stimulus is driven and popped by a monitor as the DUT issues them.
module tb_fb_port_arbiter;

  localparam int AW = 15;
  localparam int DW = 16;

  typedef struct packed {
    logic          wre;
    logic [AW-1:0] ad;
    logic [DW-1:0] din;
  } op_t;

  logic          PixelClk = 1'b0;
  logic          nRST;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          rd_refetch;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          ram_ce;
  logic          ram_wre;
  logic [AW-1:0] ram_ad;
  logic [DW-1:0] ram_din;
  logic [2:0]    fifo_level;
  logic [15:0]   stall_cnt;

  int  vectors     = 0;
  int  miscompares = 0;
  int  rd_ops      = 0;
  int  exp_stall   = 0;
  op_t sb [$];
  op_t mon_op;

  logic [DW-1:0] bram [0:(1<<AW)-1];
  logic [DW-1:0] dout;

  fb_port_arbiter #(
    .AW(AW), .DW(DW), .FIFO_DEPTH(4), .STALL_W(16)
  ) dut (
    .PixelClk   (PixelClk),
    .nRST       (nRST),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_refetch (rd_refetch),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .ram_ce     (ram_ce),
    .ram_wre    (ram_wre),
    .ram_ad     (ram_ad),
    .ram_din    (ram_din),
    .fifo_level (fifo_level),
    .stall_cnt  (stall_cnt)
  );

  always #5 PixelClk = ~PixelClk;

  // Behavioural single-port BRAM, normal write mode, registered output.
  always @(posedge PixelClk) begin
    if (ram_ce === 1'b1) begin
      if (ram_wre) bram[ram_ad] <= ram_din;
      else         dout <= bram[ram_ad];
    end
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge PixelClk) begin
    if (nRST === 1'b1 && ram_ce === 1'b1) begin
      if (!ram_wre) rd_ops++;
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $error("[TB] FAIL unexpected_op: observed wre=%0b ad=0x%0h expected no access", ram_wre, ram_ad);
      end else begin
        mon_op = sb.pop_front();
        check_output("op_wre", ram_wre, mon_op.wre);
        check_output("op_addr", ram_ad, mon_op.ad);
        if (mon_op.wre) check_output("op_data", ram_din, mon_op.din);
      end
    end
  end

  task automatic tick();
    @(posedge PixelClk);
    #1;
  endtask

  task automatic exp_rd(input logic [AW-1:0] a);
    sb.push_back({1'b0, a, 16'h0000});
  endtask

  task automatic exp_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    sb.push_back({1'b1, a, d});
  endtask

  initial begin
    logic [AW-1:0] r;
    int rd_base;
    int n;

    nRST = 1'b1; rd_en = 1'b0; rd_addr = '0; rd_refetch = 1'b0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0;

    // Reset held with a writer already presenting data
    #2 nRST = 1'b0;
    wr_valid = 1'b1; wr_addr = 15'h7ABC; wr_data = 16'hBEEF;
    tick(); tick();
    check_output("rst_ram_ce", ram_ce, 1'b0);
    check_output("rst_ram_wre", ram_wre, 1'b0);
    check_output("rst_ram_ad", ram_ad, 15'h0);
    check_output("rst_ram_din", ram_din, 16'h0);
    check_output("rst_wr_ready", wr_ready, 1'b0);
    check_output("rst_level", fifo_level, 3'd0);
    check_output("rst_stall", stall_cnt, 16'h0);
    nRST = 1'b1;
    tick();
    wr_valid = 1'b0;
    check_output("rel_wr_ready", wr_ready, 1'b1);
    check_output("rel_level", fifo_level, 3'd0);
    check_output("rel_ram_ce", ram_ce, 1'b0);

    // Elision: each address repeated 5 times, two writes drain in free slots
    rd_base = rd_ops;
    exp_rd(15'h0000);
    exp_wr(15'h0100, 16'hAAAA);
    exp_wr(15'h0101, 16'h5555);
    exp_rd(15'h0001);
    for (int i = 0; i < 10; i++) begin
      rd_en = 1'b1;
      rd_addr = (i < 5) ? 15'h0000 : 15'h0001;
      if (i == 0) begin
        wr_valid = 1'b1; wr_addr = 15'h0100; wr_data = 16'hAAAA;
      end else if (i == 1) begin
        wr_valid = 1'b1; wr_addr = 15'h0101; wr_data = 16'h5555;
      end else begin
        wr_valid = 1'b0;
      end
      tick();
      if (i == 0) check_output("elide_ad0", {ram_ce, ram_wre, ram_ad}, {2'b10, 15'h0000});
      if (i == 5) check_output("elide_ad1", {ram_ce, ram_wre, ram_ad}, {2'b10, 15'h0001});
    end
    rd_en = 1'b0; wr_valid = 1'b0;
    tick();
    check_output("elide_rd_count", rd_ops - rd_base, 2);
    check_output("elide_level", fifo_level, 3'd0);
    check_output("elide_stall", stall_cnt, 16'h0);

    // Priority: reads every cycle starve three queued writes
    for (int i = 0; i < 3; i++) begin
      rd_en = 1'b1; rd_addr = 15'h0200 + 15'(i); exp_rd(rd_addr);
      wr_valid = 1'b1; wr_addr = 15'h0300 + 15'(i); wr_data = 16'h1000 + 16'(i);
      tick();
      if (i > 0) exp_stall++;
    end
    wr_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      rd_addr = 15'h0210 + 15'(i); exp_rd(rd_addr);
      tick();
      exp_stall++;
    end
    check_output("prio_level", fifo_level, 3'd3);
    check_output("prio_stall", stall_cnt, exp_stall);
    rd_en = 1'b0;
    for (int i = 0; i < 3; i++) exp_wr(15'h0300 + 15'(i), 16'h1000 + 16'(i));
    for (int i = 0; i < 3; i++) begin
      tick();
      check_output("drain_wre", ram_wre, 1'b1);
      check_output("drain_level", fifo_level, 3'(2 - i));
    end
    tick();
    check_output("drain_idle", ram_ce, 1'b0);

    // Coherency: writing the held address forces a re-read
    rd_en = 1'b1; rd_addr = 15'h0123; exp_rd(15'h0123);
    tick();
    rd_en = 1'b0;
    wr_valid = 1'b1; wr_addr = 15'h0123; wr_data = 16'hF800; exp_wr(15'h0123, 16'hF800);
    tick();
    wr_valid = 1'b0;
    tick();
    check_output("coh_wre", ram_wre, 1'b1);
    rd_en = 1'b1; rd_addr = 15'h0123; exp_rd(15'h0123);
    tick();
    rd_en = 1'b0;
    tick();
    check_output("coh_dout", dout, 16'hF800);

    // Refetch alone invalidates; refetch with a new read leaves it held
    rd_refetch = 1'b1;
    tick();
    rd_refetch = 1'b0;
    rd_en = 1'b1; rd_addr = 15'h0123; exp_rd(15'h0123);
    tick();
    check_output("refetch_reread", {ram_ce, ram_wre}, 2'b10);
    rd_addr = 15'h0124; rd_refetch = 1'b1; exp_rd(15'h0124);
    tick();
    rd_refetch = 1'b0;
    tick();
    check_output("refetch_read_wins", ram_ce, 1'b0);
    rd_en = 1'b0;

    // Write-after-write to one address: last value wins
    wr_valid = 1'b1; wr_addr = 15'h0050; wr_data = 16'h1111; exp_wr(15'h0050, 16'h1111);
    tick();
    wr_data = 16'h2222; exp_wr(15'h0050, 16'h2222);
    tick();
    wr_valid = 1'b0;
    tick();
    rd_en = 1'b1; rd_addr = 15'h0050; exp_rd(15'h0050);
    tick();
    rd_en = 1'b0;
    tick();
    check_output("waw_dout", dout, 16'h2222);

    // Backpressure: FIFO fills under constant reads, stall counter saturates
    r = 15'h1000;
    for (int i = 0; i < 4; i++) begin
      rd_en = 1'b1; rd_addr = r; exp_rd(r); r = r + 15'd1;
      wr_valid = 1'b1; wr_addr = 15'h0400 + 15'(i); wr_data = 16'h2000 + 16'(i);
      tick();
      if (i > 0) exp_stall++;
    end
    check_output("full_wr_ready", wr_ready, 1'b0);
    check_output("full_level", fifo_level, 3'd4);
    wr_addr = 15'h0404; wr_data = 16'h2004;
    n = 65535 - exp_stall + 20;
    for (int i = 0; i < n; i++) begin
      rd_addr = r; exp_rd(r); r = r + 15'd1;
      tick();
      if (exp_stall < 65535) exp_stall++;
    end
    check_output("sat_stall", stall_cnt, exp_stall);
    check_output("sat_stall_max", stall_cnt, 16'hFFFF);
    check_output("sat_level", fifo_level, 3'd4);
    check_output("sat_wr_ready", wr_ready, 1'b0);
    rd_en = 1'b0;
    for (int i = 0; i < 5; i++) exp_wr(15'h0400 + 15'(i), 16'h2000 + 16'(i));
    tick();
    check_output("bp_level_a", fifo_level, 3'd3);
    check_output("bp_wr_ready", wr_ready, 1'b1);
    tick();
    wr_valid = 1'b0;
    check_output("bp_level_b", fifo_level, 3'd3);
    tick(); tick(); tick();
    check_output("bp_level_empty", fifo_level, 3'd0);
    check_output("bp_stall_hold", stall_cnt, 16'hFFFF);

    // Reset asserted mid-drain
    for (int i = 0; i < 3; i++) begin
      rd_en = 1'b1; rd_addr = r; exp_rd(r); r = r + 15'd1;
      wr_valid = 1'b1; wr_addr = 15'h0500 + 15'(i); wr_data = 16'h3000 + 16'(i);
      tick();
    end
    wr_valid = 1'b0; rd_en = 1'b0;
    exp_wr(15'h0500, 16'h3000);
    tick();
    check_output("mid_wre", ram_wre, 1'b1);
    check_output("mid_level", fifo_level, 3'd2);
    @(negedge PixelClk);
    #1 nRST = 1'b0;
    #1;
    check_output("mid_rst_ce", ram_ce, 1'b0);
    check_output("mid_rst_wre", ram_wre, 1'b0);
    check_output("mid_rst_ad", ram_ad, 15'h0);
    check_output("mid_rst_din", ram_din, 16'h0);
    check_output("mid_rst_ready", wr_ready, 1'b0);
    check_output("mid_rst_level", fifo_level, 3'd0);
    check_output("mid_rst_stall", stall_cnt, 16'h0);
    tick();
    nRST = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check_output("post_rst_level", fifo_level, 3'd0);
    check_output("post_rst_ce", ram_ce, 1'b0);
    check_output("scoreboard_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
